// File: rtl/riscv_pkg.sv
// riscv_pkg: datapath-wide constants shared by the RISCV register file
// and its neighbours.
//   XLEN       - architectural word width in bits
//   NUM_REGS   - number of architectural integer registers
//   REG_ADDR_W - register address width
//   ZERO_ADDR  - address of the hardwired-zero register (x0)
package riscv_pkg;

    localparam int XLEN       = 32;
    localparam int NUM_REGS   = 32;
    localparam int REG_ADDR_W = 5;
    localparam int ZERO_ADDR  = 0;

endpackage : riscv_pkg

// File: rtl/regfile_entry.sv
// regfile_entry: one WIDTH-bit register-file word with per-byte write
// enables.
//   clock   - rising-edge clock
//   reset_n - asynchronous active-low reset, clears the word
//   clear   - synchronous clear; has priority over any byte enable
//   byte_en - per-byte load enables; bit i loads d[8i+7:8i]
//   d       - write data
//   q       - stored word
module regfile_entry
    import riscv_pkg::*;
#(
    parameter int WIDTH = XLEN
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               clear,
    input  logic [WIDTH/8-1:0] byte_en,
    input  logic [WIDTH-1:0]   d,
    output logic [WIDTH-1:0]   q
);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            q <= '0;
        end else if (clear) begin
            q <= '0;
        end else begin
            for (int unsigned i = 0; i < WIDTH / 8; i++) begin
                if (byte_en[i]) begin
                    q[8*i +: 8] <= d[8*i +: 8];
                end
            end
        end
    end

endmodule : regfile_entry

// File: rtl/register_file.sv
// register_file: DEPTH x WIDTH register array, one byte-strobed write port
// and two combinational read ports.
//   clock    - rising-edge clock
//   reset_n  - asynchronous active-low reset, clears every entry
//   clear    - synchronous clear of all entries; wins over a same-edge write
//   we       - write enable
//   waddr    - write address (addresses >= DEPTH are ignored)
//   wdata    - write data
//   wstrb    - per-byte write strobes; bit i covers wdata[8i+7:8i]
//   raddr_a  - read address, port A (addresses >= DEPTH read 0)
//   rdata_a  - read data, port A
//   raddr_b  - read address, port B
//   rdata_b  - read data, port B
// Parameters: WIDTH (multiple of 8), DEPTH (2..256), ZERO_REG (1: entry 0
// reads 0 and ignores writes). ADDR_W is derived from DEPTH.
// Build option: define REGFILE_BYPASS_EN to forward a same-cycle write to
// matching read ports (merged with the stored bytes under the strobes).
module register_file
    import riscv_pkg::*;
#(
    parameter  int WIDTH    = XLEN,
    parameter  int DEPTH    = NUM_REGS,
    parameter  int ZERO_REG = 1,
    localparam int ADDR_W   = $clog2(DEPTH)
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               clear,
    input  logic               we,
    input  logic [ADDR_W-1:0]  waddr,
    input  logic [WIDTH-1:0]   wdata,
    input  logic [WIDTH/8-1:0] wstrb,
    input  logic [ADDR_W-1:0]  raddr_a,
    output logic [WIDTH-1:0]   rdata_a,
    input  logic [ADDR_W-1:0]  raddr_b,
    output logic [WIDTH-1:0]   rdata_b
);

    logic [WIDTH-1:0] words [DEPTH];

    // Entry 0 is a constant when hardwired; out-of-range write addresses
    // simply never match any entry's decode.
    for (genvar g = 0; g < DEPTH; g++) begin : g_entry
        if (ZERO_REG != 0 && g == ZERO_ADDR) begin : g_zero
            assign words[g] = '0;
        end else begin : g_reg
            logic [WIDTH/8-1:0] byte_en;
            assign byte_en = (we && waddr == ADDR_W'(g)) ? wstrb : '0;

            regfile_entry #(
                .WIDTH (WIDTH)
            ) u_entry (
                .clock   (clock),
                .reset_n (reset_n),
                .clear   (clear),
                .byte_en (byte_en),
                .d       (wdata),
                .q       (words[g])
            );
        end
    end

    // Read muxes: default 0 covers addresses beyond DEPTH.
    logic [WIDTH-1:0] stored_a;
    logic [WIDTH-1:0] stored_b;

    always_comb begin
        stored_a = '0;
        stored_b = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (raddr_a == ADDR_W'(i)) stored_a = words[i];
            if (raddr_b == ADDR_W'(i)) stored_b = words[i];
        end
    end

`ifdef REGFILE_BYPASS_EN
    logic             wr_hit;
    logic [WIDTH-1:0] wmask;

    // Forward only writes that will actually land this edge: enabled,
    // not cleared, in range and not aimed at a hardwired zero entry.
    always_comb begin
        wr_hit = 1'b0;
        if (we && !clear) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (waddr == ADDR_W'(i) &&
                    !(ZERO_REG != 0 && i == unsigned'(ZERO_ADDR))) begin
                    wr_hit = 1'b1;
                end
            end
        end
        wmask = '0;
        for (int unsigned b = 0; b < WIDTH / 8; b++) begin
            wmask[8*b +: 8] = {8{wstrb[b]}};
        end
    end

    always_comb begin
        rdata_a = stored_a;
        rdata_b = stored_b;
        if (wr_hit && raddr_a == waddr) rdata_a = (stored_a & ~wmask) | (wdata & wmask);
        if (wr_hit && raddr_b == waddr) rdata_b = (stored_b & ~wmask) | (wdata & wmask);
    end
`else
    assign rdata_a = stored_a;
    assign rdata_b = stored_b;
`endif

endmodule : register_file

// File: tb/tb_register_file.sv
// tb_register_file: directed checks of register_file. Three instances share
// one stimulus: dut_z (32 entries, ZERO_REG=1), dut_nz (32 entries,
// ZERO_REG=0) and dut_24 (24 entries, ZERO_REG=1). Expectations follow
// REGFILE_BYPASS_EN when it is defined.
module tb_register_file;
    import riscv_pkg::*;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic                  clock;
    logic                  reset_n;
    logic                  clear;
    logic                  we;
    logic [REG_ADDR_W-1:0] waddr;
    logic [XLEN-1:0]       wdata;
    logic [XLEN/8-1:0]     wstrb;
    logic [REG_ADDR_W-1:0] raddr_a;
    logic [REG_ADDR_W-1:0] raddr_b;
    logic [XLEN-1:0]       z_a, z_b, nz_a, nz_b, d24_a, d24_b;

    int compared   = 0;
    int mismatched = 0;

    register_file #(.WIDTH(XLEN), .DEPTH(NUM_REGS), .ZERO_REG(1)) dut_z (
        .clock(clock), .reset_n(reset_n), .clear(clear), .we(we),
        .waddr(waddr), .wdata(wdata), .wstrb(wstrb),
        .raddr_a(raddr_a), .rdata_a(z_a), .raddr_b(raddr_b), .rdata_b(z_b));

    register_file #(.WIDTH(XLEN), .DEPTH(NUM_REGS), .ZERO_REG(0)) dut_nz (
        .clock(clock), .reset_n(reset_n), .clear(clear), .we(we),
        .waddr(waddr), .wdata(wdata), .wstrb(wstrb),
        .raddr_a(raddr_a), .rdata_a(nz_a), .raddr_b(raddr_b), .rdata_b(nz_b));

    register_file #(.WIDTH(XLEN), .DEPTH(24), .ZERO_REG(1)) dut_24 (
        .clock(clock), .reset_n(reset_n), .clear(clear), .we(we),
        .waddr(waddr), .wdata(wdata), .wstrb(wstrb),
        .raddr_a(raddr_a), .rdata_a(d24_a), .raddr_b(raddr_b), .rdata_b(d24_b));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [XLEN-1:0] got,
                            input logic [XLEN-1:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after a rising edge.
    task automatic wr(input logic [REG_ADDR_W-1:0] a, input logic [XLEN-1:0] d,
                      input logic [XLEN/8-1:0] s);
        we = 1'b1; waddr = a; wdata = d; wstrb = s;
        @(posedge clock); #1;
        we = 1'b0; wstrb = '0;
    endtask

    task automatic rd(input logic [REG_ADDR_W-1:0] a, input logic [REG_ADDR_W-1:0] b);
        raddr_a = a; raddr_b = b;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n = 1'b0; clear = 1'b0; we = 1'b0;
        waddr = '0; wdata = '0; wstrb = '0; raddr_a = '0; raddr_b = '0;

        // Reset state
        #3;
        rd(5, 31);
        check_eq("rst_a5", z_a, 32'h0);
        check_eq("rst_b31", nz_b, 32'h0);
        @(posedge clock); #1;
        reset_n = 1'b1;
        @(posedge clock); #1;

        // Byte strobes
        wr(3, 32'h11223344, 4'b1111);
        rd(3, 3);
        check_eq("full_wr3", z_a, 32'h11223344);
        wr(3, 32'hAABBCCDD, 4'b0101);
        rd(3, 3);
        check_eq("strb_z_a", z_a, 32'h11BB33DD);
        check_eq("strb_24_b", d24_b, 32'h11BB33DD);
        wr(3, 32'hFFFFFFFF, 4'b0000);
        rd(3, 3);
        check_eq("strb_zero", z_b, 32'h11BB33DD);
        wr(3, 32'h00000000, 4'b1000);
        rd(3, 3);
        check_eq("strb_hi", nz_a, 32'h00BB33DD);

        // Zero register
        wr(0, 32'hFFFFFFFF, 4'b1111);
        rd(0, 0);
        check_eq("x0_z_a", z_a, 32'h0);
        check_eq("x0_z_b", z_b, 32'h0);
        check_eq("x0_nz_a", nz_a, 32'hFFFFFFFF);
        check_eq("x0_nz_b", nz_b, 32'hFFFFFFFF);

        // Same-cycle read/write on entry 9
        wr(9, 32'h00000001, 4'b1111);
        rd(9, 9);
        check_eq("raw_old", z_a, 32'h00000001);
        we = 1'b1; waddr = 9; wdata = 32'h00000002; wstrb = 4'b1111;
        #2;
        check_eq("raw_same_a", z_a, BYPASS ? 32'h00000002 : 32'h00000001);
        check_eq("raw_same_b", nz_b, BYPASS ? 32'h00000002 : 32'h00000001);
        @(posedge clock); #1;
        we = 1'b0;
        #1;
        check_eq("raw_next", z_a, 32'h00000002);

        // Partial-strobe forwarding merges with stored bytes
        we = 1'b1; waddr = 9; wdata = 32'hAABBCCDD; wstrb = 4'b0010;
        #2;
        check_eq("raw_merge", z_a, BYPASS ? 32'h0000CC02 : 32'h00000002);
        @(posedge clock); #1;
        we = 1'b0;
        rd(9, 9);
        check_eq("merge_next", z_b, 32'h0000CC02);

        // x0 never forwards on a hardwired instance
        we = 1'b1; waddr = 0; wdata = 32'h12345678; wstrb = 4'b1111;
        rd(0, 0);
        check_eq("x0_nobyp", z_b, 32'h0);
        check_eq("x0_nz_byp", nz_b, BYPASS ? 32'h12345678 : 32'hFFFFFFFF);
        @(posedge clock); #1;
        we = 1'b0;

        // Out of range on the 24-entry instance
        we = 1'b1; waddr = 30; wdata = 32'h5A5A5A5A; wstrb = 4'b1111;
        rd(30, 30);
        check_eq("oor_same", d24_b, 32'h0);
        @(posedge clock); #1;
        we = 1'b0;
        rd(30, 30);
        check_eq("oor_24_b", d24_b, 32'h0);
        check_eq("oor_z_a", z_a, 32'h5A5A5A5A);
        rd(3, 9);
        check_eq("oor_24_e3", d24_a, 32'h00BB33DD);
        check_eq("oor_24_e9", d24_b, 32'h0000CC02);

        // Clear beats a same-edge write
        for (int i = 1; i < 32; i++) wr(REG_ADDR_W'(i), 32'h100 + i, 4'b1111);
        rd(7, 31);
        check_eq("load_7", z_a, 32'h00000107);
        check_eq("load_31", nz_b, 32'h0000011F);
        clear = 1'b1; we = 1'b1; waddr = 7; wdata = 32'h12345678; wstrb = 4'b1111;
        #2;
        check_eq("clr_nobyp", z_a, 32'h00000107);
        @(posedge clock); #1;
        clear = 1'b0; we = 1'b0;
        for (int i = 0; i < 32; i++) begin
            rd(REG_ADDR_W'(i), REG_ADDR_W'(i));
            check_eq($sformatf("clr_z_%0d", i), z_a, 32'h0);
            check_eq($sformatf("clr_nz_%0d", i), nz_b, 32'h0);
        end

        // Asynchronous reset mid-cycle
        wr(5, 32'hDEADBEEF, 4'b1111);
        rd(5, 5);
        check_eq("pre_rst", z_a, 32'hDEADBEEF);
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("async_rst", z_a, 32'h0);
        check_eq("async_rst24", d24_b, 32'h0);
        @(posedge clock); #1;
        reset_n = 1'b1;

        // Reset held across a write edge leaves the entry at 0
        we = 1'b1; waddr = 5; wdata = 32'hCAFEF00D; wstrb = 4'b1111;
        #2;
        reset_n = 1'b0;
        @(posedge clock); #1;
        we = 1'b0;
        reset_n = 1'b1;
        rd(5, 5);
        check_eq("rst_mid_wr", z_a, 32'h0);
        check_eq("rst_mid_wr_nz", nz_b, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule : tb_register_file

// File: doc/register_file.md
# register_file

Parametrised multi-port register array for the RISCV datapath, successor to the single enabled register. Holds DEPTH words of WIDTH bits with one write port carrying byte strobes and two independent read ports. Sits between decode (read addresses) and writeback (write port); feeds ALU operand registers directly.

## Interface
- WIDTH, 32, word width in bits; multiple of 8
- DEPTH, 32, number of entries; 2..256
- ADDR_W, $clog2(DEPTH), address width; derived, not overridden
- ZERO_REG, 1, when 1 entry 0 is hardwired to zero

- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- clear  in  1  synchronous clear of all entries
- we  in  1  write enable
- waddr  in  ADDR_W  write address
- wdata  in  WIDTH  write data
- wstrb  in  WIDTH/8  per-byte write strobes; bit i covers wdata[8i+7:8i]
- raddr_a  in  ADDR_W  read address, port A
- rdata_a  out  WIDTH  read data, port A
- raddr_b  in  ADDR_W  read address, port B
- rdata_b  out  WIDTH  read data, port B

## Operation
- Reset (reset_n low): every entry cleared to 0 immediately, independent of clock; rdata_a/rdata_b read 0 while reset is held.
- Write: on rising clock with we=1, each byte of entry waddr whose wstrb bit is 1 takes the matching wdata byte; other bytes hold.
- we=1 with wstrb all-zero: no change.
- ZERO_REG=1: writes to address 0 ignored; reads of address 0 return 0.
- waddr >= DEPTH (non-power-of-2 DEPTH): write ignored. raddr >= DEPTH: read returns 0.
- clear=1 at rising clock: all entries go to 0; a write in the same cycle is discarded (clear wins).
- Reads are combinational from stored contents; both ports may address the same entry.
- reset_n asserted mid-write: entry ends at 0; no partial write survives.

## Timing
- Write latency: data visible on read ports in the cycle after the writing edge (without bypass).
- Read latency: zero cycles (combinational address-to-data).
- Clear latency: entries read 0 in the cycle after the clear edge.
- Bypass (see Configuration): same-cycle forwarding is combinational; no added register stage.

## Configuration
- REGFILE_BYPASS_EN defined: when we=1, clear=0, waddr valid and writable, and raddr_x == waddr, rdata_x returns the merged word (strobed bytes from wdata, other bytes from stored entry) in the same cycle as the write. Address 0 with ZERO_REG=1 never bypasses.
- Undefined: no forwarding; rdata_x returns stored contents, so read-after-write in the same cycle returns the old value.

## Structure
- Shared package riscv_pkg: XLEN (32), NUM_REGS (32), REG_ADDR_W (5), ZERO_ADDR (0); top-level instantiation takes WIDTH/DEPTH from these.
- One sub-module regfile_entry: one WIDTH-bit word with asynchronous active-low reset, synchronous clear, and per-byte enables; register_file generates DEPTH instances (entry 0 omitted when ZERO_REG=1) plus write decode and read muxes.

## Test plan
- Reset: write 0xDEADBEEF to entry 5, pulse reset_n low mid-cycle -> rdata_a (raddr_a=5) reads 0x00000000 without a clock edge.
- Byte strobes: entry 3 = 0x11223344, write 0xAABBCCDD with wstrb=4'b0101 -> entry 3 reads 0x11BB33DD next cycle.
- Zero register: write 0xFFFFFFFF to address 0, ZERO_REG=1 -> both ports read 0 at address 0; with ZERO_REG=0 -> read 0xFFFFFFFF.
- Clear vs write: entries 1..31 loaded, clear=1 and we=1 (waddr=7, wdata=0x12345678) same edge -> every entry, including 7, reads 0.
- Same-cycle read/write on entry 9 (old 0x00000001, new 0x00000002, wstrb=4'b1111): with REGFILE_BYPASS_EN -> rdata_a=0x00000002 in write cycle; without -> 0x00000001 then 0x00000002 next cycle.
- Out of range, DEPTH=24: write 0x5A5A5A5A to address 30 -> no entry changes; raddr_b=30 reads 0.
